// File: rtl/gpio_ctrl_irq_bank.sv
// Per-bank GPIO input engine: synchroniser, per-pin debounce, edge/level
// interrupt detection, sticky W1C status and a registered bank interrupt.
// Optional debounce prescaler is enabled with `define GPIO_CTRL_DB_PRESCALE_EN.
module gpio_ctrl_irq_bank #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      gpio_in,
  input  logic [WIDTH-1:0]      db_enable,
  input  logic [DB_CNT_W-1:0]   db_threshold,
  input  logic [WIDTH-1:0]      intr_enable,
  input  logic [2*WIDTH-1:0]    intr_type,
  input  logic [WIDTH-1:0]      status_clr,
`ifdef GPIO_CTRL_DB_PRESCALE_EN
  input  logic [15:0]           db_prescale,
`endif
  output logic [WIDTH-1:0]      gpio_filtered,
  output logic [WIDTH-1:0]      intr_status,
  output logic                  bank_irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_synced;
  logic [WIDTH-1:0][DB_CNT_W-1:0]    r_cnt;
  logic [WIDTH-1:0][DB_CNT_W-1:0]    w_cntInc;
  logic [WIDTH-1:0]                  w_reach;
  logic [DB_CNT_W-1:0]               w_thr;
  logic [WIDTH-1:0]                  r_filtered;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  w_rise;
  logic [WIDTH-1:0]                  w_fall;
  logic [WIDTH-1:0]                  w_event;
  logic [WIDTH-1:0]                  r_status;
  logic                              r_irq;
  logic                              w_tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef GPIO_CTRL_DB_PRESCALE_EN
  logic [15:0] r_presc;

  assign w_tick = (r_presc == db_prescale);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // A zero threshold behaves like one so the filter can never stall.
  assign w_thr = (db_threshold == '0) ? DB_CNT_W'(1) : db_threshold;

  always_comb begin
    w_cntInc = '0;
    w_reach  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cntInc[i] = (r_cnt[i] == '1) ? r_cnt[i] : r_cnt[i] + DB_CNT_W'(1);
      w_reach[i]  = ({1'b0, r_cnt[i]} + (DB_CNT_W+1)'(1)) >= {1'b0, w_thr};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_filtered <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!db_enable[i]) begin
          r_filtered[i] <= w_synced[i];
          r_cnt[i]      <= '0;
        end else if (w_synced[i] == r_filtered[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (w_reach[i]) begin
            r_filtered[i] <= w_synced[i];
            r_cnt[i]      <= '0;
          end else begin
            r_cnt[i] <= w_cntInc[i];
          end
        end
      end
    end
  end

  assign w_rise = r_filtered & ~r_prev;
  assign w_fall = ~r_filtered & r_prev;

  // prev tracks filtered regardless of type, so retyping a pin cannot fake an edge.
  always_comb begin
    w_event = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (intr_type[2*i +: 2])
        2'b00:   w_event[i] = w_rise[i];
        2'b01:   w_event[i] = w_fall[i];
        2'b10:   w_event[i] = w_rise[i] | w_fall[i];
        default: w_event[i] = r_filtered[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev   <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_prev   <= r_filtered;
      r_status <= (r_status & ~status_clr) | (w_event & intr_enable);
      r_irq    <= |r_status;
    end
  end

  assign gpio_filtered = r_filtered;
  assign intr_status   = r_status;
  assign bank_irq      = r_irq;

endmodule
